// File: rtl/mul_pkg.sv
// Shared constants and FSM encoding for the multiplier issue controller.
package mul_pkg;

  // Booth iteration counts of the attached radix-4 multiplier
  localparam int unsigned LAT_SIGNED   = 16;
  localparam int unsigned LAT_UNSIGNED = 17;
  localparam int unsigned CNT_W        = 5;
  localparam int unsigned OP_W         = 32;
  localparam int unsigned PROD_W       = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_req_fifo.sv
// Request queue: DEPTH entries of packed {a, b, signed, tag}.
// Ports: push/wdata write side, pop/rdata read side (rdata is the head,
// valid while !empty), full/empty flags. Pointers carry one extra wrap bit.
module mul_req_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 69
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PW    = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; reset discards all queued entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: only read while non-empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for an external radix-4 Booth multiplier.
// Queues requests, issues one multiply at a time with a one-cycle mul_start,
// waits LAT+2 edges, then holds the product on rsp_* until accepted.
// Ports: req_* request handshake and payload, rsp_* response handshake and
// product, mul_* drive to the multiplier, mul_s product from the multiplier.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_a,
  input  logic [OP_W-1:0]   req_b,
  input  logic              req_signed,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_p,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  output logic              mul_is_signed,
  input  logic [PROD_W-1:0] mul_s
);

  localparam int unsigned DATA_W = 2 * OP_W + 1 + TAG_W;

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              rsp_valid_d;
  logic [PROD_W-1:0] rsp_p_d;
  logic [TAG_W-1:0]  rsp_tag_d;
  logic              mul_start_d;
  logic [OP_W-1:0]   mul_a_d, mul_b_d;
  logic              mul_is_signed_d;
  logic              issue_c;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] head;
  logic [OP_W-1:0]   head_a, head_b;
  logic              head_sgn;
  logic [TAG_W-1:0]  head_tag;

  // req_ready depends only on queue state, never on req_valid
  assign req_ready = !fifo_full;

  mul_req_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid && req_ready),
    .wdata ({req_a, req_b, req_signed, req_tag}),
    .pop   (issue_c),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_a   = head[DATA_W-1 -: OP_W];
  assign head_b   = head[DATA_W-OP_W-1 -: OP_W];
  assign head_sgn = head[TAG_W];
  assign head_tag = head[TAG_W-1:0];

  // Next-state and next-output logic
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tag_d           = tag_q;
    rsp_valid_d     = rsp_valid;
    rsp_p_d         = rsp_p;
    rsp_tag_d       = rsp_tag;
    mul_start_d     = 1'b0;
    mul_a_d         = mul_a;
    mul_b_d         = mul_b;
    mul_is_signed_d = mul_is_signed;
    issue_c         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        issue_c = !fifo_empty;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_p_d     = mul_s;
          rsp_tag_d   = tag_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          issue_c     = !fifo_empty;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Issue pops the head, latches operands and arms the countdown
    if (issue_c) begin
      mul_a_d         = head_a;
      mul_b_d         = head_b;
      mul_is_signed_d = head_sgn;
      tag_d           = head_tag;
      mul_start_d     = 1'b1;
      cnt_d           = head_sgn ? CNT_W'(LAT_SIGNED + 1) : CNT_W'(LAT_UNSIGNED + 1);
      state_d         = ST_WAIT;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tag_q         <= '0;
      rsp_valid     <= 1'b0;
      rsp_p         <= '0;
      rsp_tag       <= '0;
      mul_start     <= 1'b0;
      mul_a         <= '0;
      mul_b         <= '0;
      mul_is_signed <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tag_q         <= tag_d;
      rsp_valid     <= rsp_valid_d;
      rsp_p         <= rsp_p_d;
      rsp_tag       <= rsp_tag_d;
      mul_start     <= mul_start_d;
      mul_a         <= mul_a_d;
      mul_b         <= mul_b_d;
      mul_is_signed <= mul_is_signed_d;
    end
  end

endmodule
